// File: rtl/frame_sync_ctrl.sv
// Frame sync-state controller: qualifies aligner headers against the frame period and
// walks HUNT->PRESYNC->SYNC/FLYWHEEL. Optional counters enabled by FRAME_SYNC_STATS_EN.
module frame_sync_ctrl #(
   parameter int unsigned  FRAME_LEN   = 12,
   parameter int unsigned  CONFIRM_CNT = 3,
   parameter int unsigned  LOSS_CNT    = 4,
   parameter int unsigned  POS_W       = 4,
   parameter int unsigned  HDR_POS     = 0,
   localparam int unsigned CNT_W       = $clog2(FRAME_LEN)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             frame_detect,
   input  logic [POS_W-1:0] fr_byte_position,
   output logic             in_sync,
   output logic [1:0]       sync_state,
   output logic             frame_start,
   output logic             payload_valid,
   output logic [CNT_W-1:0] byte_idx,
   output logic             aligner_restart,
   output logic             lof
`ifdef FRAME_SYNC_STATS_EN
   ,
   output logic [15:0]      miss_total,
   output logic [15:0]      lof_total
`endif
);

   localparam int unsigned      GOOD_W   = $clog2(CONFIRM_CNT + 1);
   localparam int unsigned      MISS_W   = $clog2(LOSS_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      ST_HUNT     = 2'b00,
      ST_PRESYNC  = 2'b01,
      ST_SYNC     = 2'b10,
      ST_FLYWHEEL = 2'b11
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [GOOD_W-1:0]   good, good_nxt, good_inc;
   logic [MISS_W-1:0]   miss, miss_nxt, miss_inc;
   logic                hdr_ok, due;
   logic                sync_nxt, restart_nxt, lof_nxt, miss_evt;

   assign hdr_ok   = frame_detect && (fr_byte_position == POS_W'(HDR_POS));
   assign due      = (cnt == '0);
   assign good_inc = (good == GOOD_W'(CONFIRM_CNT)) ? good : good + GOOD_W'(1);
   assign miss_inc = (miss == MISS_W'(LOSS_CNT)) ? miss : miss + MISS_W'(1);

   // Next-state, counters and pulse decisions for the current byte slot.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      good_nxt    = good;
      miss_nxt    = miss;
      restart_nxt = 1'b0;
      lof_nxt     = 1'b0;
      miss_evt    = 1'b0;
      if (!enable) begin
         state_nxt = ST_HUNT;
         cnt_nxt   = '0;
         good_nxt  = '0;
         miss_nxt  = '0;
      end else begin
         unique case (state)
            ST_HUNT: begin
               if (hdr_ok) begin
                  state_nxt = ST_PRESYNC;
                  cnt_nxt   = CNT_W'(1);
                  good_nxt  = '0;
               end
            end
            ST_PRESYNC: begin
               if (due && hdr_ok) begin
                  good_nxt = good_inc;
                  if (good_inc == GOOD_W'(CONFIRM_CNT)) begin
                     state_nxt = ST_SYNC;
                     miss_nxt  = '0;
                  end
               end else if (due) begin
                  state_nxt   = ST_HUNT;
                  restart_nxt = 1'b1;
               end else if (hdr_ok) begin
                  // Early header: treat it as a fresh anchor.
                  cnt_nxt  = CNT_W'(1);
                  good_nxt = '0;
               end
            end
            ST_SYNC, ST_FLYWHEEL: begin
               if (due && hdr_ok) begin
                  state_nxt = ST_SYNC;
                  miss_nxt  = '0;
               end else if (due) begin
                  miss_evt = 1'b1;
                  if (miss_inc == MISS_W'(LOSS_CNT)) begin
                     state_nxt   = ST_HUNT;
                     lof_nxt     = 1'b1;
                     restart_nxt = 1'b1;
                     cnt_nxt     = '0;
                     miss_nxt    = '0;
                  end else begin
                     state_nxt = ST_FLYWHEEL;
                     miss_nxt  = miss_inc;
                  end
               end
            end
            default: state_nxt = ST_HUNT;
         endcase
      end
      sync_nxt = (state_nxt == ST_SYNC) || (state_nxt == ST_FLYWHEEL);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= ST_HUNT;
         cnt             <= '0;
         good            <= '0;
         miss            <= '0;
         in_sync         <= 1'b0;
         frame_start     <= 1'b0;
         payload_valid   <= 1'b0;
         byte_idx        <= '0;
         aligner_restart <= 1'b0;
         lof             <= 1'b0;
      end else begin
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         good            <= good_nxt;
         miss            <= miss_nxt;
         in_sync         <= sync_nxt;
         frame_start     <= sync_nxt && due;
         payload_valid   <= sync_nxt && !due;
         byte_idx        <= enable ? cnt : '0;
         aligner_restart <= restart_nxt;
         lof             <= lof_nxt;
      end
   end

   assign sync_state = state;

`ifdef FRAME_SYNC_STATS_EN
   // Saturating event counters; survive enable=0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         miss_total <= '0;
         lof_total  <= '0;
      end else begin
         if (miss_evt && (miss_total != 16'hFFFF)) miss_total <= miss_total + 16'd1;
         if (lof_nxt && (lof_total != 16'hFFFF))   lof_total  <= lof_total + 16'd1;
      end
   end
`endif

endmodule
